// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and controller states for the parametrised LCD controller.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package lcd_ctrl_pkg;

  // Host command codes; 14 and 15 are reserved and behave as no-ops.
  typedef enum logic [3:0] {
    CMD_WRITE  = 4'd0,
    CMD_UP     = 4'd1,
    CMD_DOWN   = 4'd2,
    CMD_LEFT   = 4'd3,
    CMD_RIGHT  = 4'd4,
    CMD_AVG    = 4'd5,
    CMD_MIRX   = 4'd6,
    CMD_MIRY   = 4'd7,
    CMD_MAX    = 4'd8,
    CMD_MIN    = 4'd9,
    CMD_ROTCW  = 4'd10,
    CMD_ROTCCW = 4'd11,
    CMD_ORIGIN = 4'd12,
    CMD_RELOAD = 4'd13
  } cmd_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/lcd_window_alu.sv
// 2x2 window pixel operator: average, max, min, mirrors and rotations.
// Latency: purely combinational, results valid in the same cycle as the inputs.
// Backpressure: none; we_o tells the caller whether the window must be rewritten.
module lcd_window_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] tl_i,
  input  logic [DW-1:0] tr_i,
  input  logic [DW-1:0] bl_i,
  input  logic [DW-1:0] br_i,
  output logic [DW-1:0] tl_o,
  output logic [DW-1:0] tr_o,
  output logic [DW-1:0] bl_o,
  output logic [DW-1:0] br_o,
  output logic          we_o
);

  logic [DW+1:0] sum;
  logic [DW-1:0] avg;
  logic [DW-1:0] max_top, max_bot, max_all;
  logic [DW-1:0] min_top, min_bot, min_all;

  // Reductions over the window; the sum carries two extra bits so it never wraps.
  always_comb begin
    sum     = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
    avg     = DW'(sum >> 2);
    max_top = (tl_i > tr_i) ? tl_i : tr_i;
    max_bot = (bl_i > br_i) ? bl_i : br_i;
    max_all = (max_top > max_bot) ? max_top : max_bot;
    min_top = (tl_i < tr_i) ? tl_i : tr_i;
    min_bot = (bl_i < br_i) ? bl_i : br_i;
    min_all = (min_top < min_bot) ? min_top : min_bot;
  end

  // Select the rewritten window; commands that do not touch pixels leave we_o low.
  always_comb begin
    tl_o = tl_i;
    tr_o = tr_i;
    bl_o = bl_i;
    br_o = br_i;
    we_o = 1'b0;
    case (op_i)
      CMD_AVG: begin
        tl_o = avg; tr_o = avg; bl_o = avg; br_o = avg;
        we_o = 1'b1;
      end
      CMD_MIRX: begin
        tl_o = tr_i; tr_o = tl_i; bl_o = br_i; br_o = bl_i;
        we_o = 1'b1;
      end
      CMD_MIRY: begin
        tl_o = bl_i; bl_o = tl_i; tr_o = br_i; br_o = tr_i;
        we_o = 1'b1;
      end
      CMD_MAX: begin
        tl_o = max_all; tr_o = max_all; bl_o = max_all; br_o = max_all;
        we_o = 1'b1;
      end
      CMD_MIN: begin
        tl_o = min_all; tr_o = min_all; bl_o = min_all; br_o = min_all;
        we_o = 1'b1;
      end
      CMD_ROTCW: begin
        tl_o = bl_i; tr_o = tl_i; br_o = tr_i; bl_o = br_i;
        we_o = 1'b1;
      end
      CMD_ROTCCW: begin
        tl_o = tr_i; tr_o = br_i; br_o = bl_i; bl_o = tl_i;
        we_o = 1'b1;
      end
      default: begin
        we_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: ROM load, 2x2 window commands, IRB write-back.
// Latency: load N+2 cycles, window/move commands 1 cycle, write-back N+1 cycles.
// Backpressure: busy high blocks commands; cmd_valid while busy is dropped, not queued.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [DW-1:0] IRB_D,
  output logic [AW-1:0] IRB_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_ORG  = XW'(IMG_W / 2);
  localparam logic [YW-1:0] Y_ORG  = YW'(IMG_H / 2);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(1);
  localparam logic [YW-1:0] Y_MIN  = YW'(1);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);

  state_e        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          rom_en_q, rom_en_d;     // active-low ROM enable
  logic [AW-1:0] rom_a_q, rom_a_d;
  logic          cap_vld_q, cap_vld_d;   // IROM_Q holds data for cap_a_q this cycle
  logic [AW-1:0] cap_a_q, cap_a_d;
  logic          irb_rw_q, irb_rw_d;
  logic [AW-1:0] irb_a_q, irb_a_d;
  logic          done_q, done_d;

  logic [DW-1:0] pix_q [N];

  logic [XW-1:0] xm1;
  logic [YW-1:0] ym1;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic [DW-1:0] w_tl, w_tr, w_bl, w_br;
  logic [DW-1:0] r_tl, r_tr, r_bl, r_br;
  logic          alu_we;
  logic          win_we;

  // Power-of-two dimensions make row*IMG_W+col a plain concatenation.
  assign xm1  = x_q - X_MIN;
  assign ym1  = y_q - Y_MIN;
  assign a_tl = {ym1, xm1};
  assign a_tr = {ym1, x_q};
  assign a_bl = {y_q, xm1};
  assign a_br = {y_q, x_q};

  assign w_tl = pix_q[a_tl];
  assign w_tr = pix_q[a_tr];
  assign w_bl = pix_q[a_bl];
  assign w_br = pix_q[a_br];

  lcd_window_alu #(
    .DW (DW)
  ) u_alu (
    .op_i (cmd_q),
    .tl_i (w_tl),
    .tr_i (w_tr),
    .bl_i (w_bl),
    .br_i (w_br),
    .tl_o (r_tl),
    .tr_o (r_tr),
    .bl_o (r_bl),
    .br_o (r_br),
    .we_o (alu_we)
  );

  assign win_we = (state_q == ST_EXEC) && alu_we;

  // Control state register; reset restarts the ROM load from address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_LOAD;
      cmd_q     <= '0;
      x_q       <= X_ORG;
      y_q       <= Y_ORG;
      rom_en_q  <= 1'b1;
      rom_a_q   <= '0;
      cap_vld_q <= 1'b0;
      cap_a_q   <= '0;
      irb_rw_q  <= 1'b1;
      irb_a_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rom_en_q  <= rom_en_d;
      rom_a_q   <= rom_a_d;
      cap_vld_q <= cap_vld_d;
      cap_a_q   <= cap_a_d;
      irb_rw_q  <= irb_rw_d;
      irb_a_q   <= irb_a_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic for the LOAD / IDLE / EXEC / WRITE sequencer.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    x_d       = x_q;
    y_d       = y_q;
    rom_en_d  = rom_en_q;
    rom_a_d   = rom_a_q;
    irb_rw_d  = irb_rw_q;
    irb_a_d   = irb_a_q;
    done_d    = 1'b0;
    // The ROM returns data one cycle after an enabled address, so remember which.
    cap_vld_d = ~rom_en_q;
    cap_a_d   = rom_a_q;

    case (state_q)
      ST_LOAD: begin
        if (rom_en_q) begin
          // Enable high with a pending capture means the last pixel lands now.
          if (cap_vld_q) begin
            state_d = ST_IDLE;
          end else begin
            rom_en_d = 1'b0;
          end
        end else if (rom_a_q == A_LAST) begin
          rom_en_d = 1'b1;
        end else begin
          rom_a_d = rom_a_q + AW'(1);
        end
      end

      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d = cmd;
          case (cmd)
            CMD_WRITE: begin
              state_d  = ST_WRITE;
              irb_rw_d = 1'b0;
              irb_a_d  = '0;
            end
            CMD_RELOAD: begin
              state_d = ST_LOAD;
              rom_a_d = '0;
              x_d     = X_ORG;
              y_d     = Y_ORG;
            end
            default: begin
              state_d = ST_EXEC;
            end
          endcase
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        case (cmd_q)
          CMD_UP:     if (y_q != Y_MIN) y_d = y_q - YW'(1);
          CMD_DOWN:   if (y_q != Y_MAX) y_d = y_q + YW'(1);
          CMD_LEFT:   if (x_q != X_MIN) x_d = x_q - XW'(1);
          CMD_RIGHT:  if (x_q != X_MAX) x_d = x_q + XW'(1);
          CMD_ORIGIN: begin
            x_d = X_ORG;
            y_d = Y_ORG;
          end
          default: begin
            x_d = x_q;
          end
        endcase
      end

      ST_WRITE: begin
        if (irb_a_q == A_LAST) begin
          irb_rw_d = 1'b1;
          irb_a_d  = '0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          irb_a_d = irb_a_q + AW'(1);
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Image buffer: filled from the ROM during load, rewritten by window ops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) pix_q[i] <= '0;
    end else begin
      if (cap_vld_q) pix_q[cap_a_q] <= IROM_Q;
      if (win_we) begin
        pix_q[a_tl] <= r_tl;
        pix_q[a_tr] <= r_tr;
        pix_q[a_bl] <= r_bl;
        pix_q[a_br] <= r_br;
      end
    end
  end

  assign IROM_EN = rom_en_q;
  assign IROM_A  = rom_a_q;
  assign IRB_RW  = irb_rw_q;
  assign IRB_A   = irb_a_q;
  assign IRB_D   = irb_rw_q ? '0 : pix_q[irb_a_q];
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param with default 8x8x8 parameters.
// Expected write-back streams come from a behavioural image model via a queue.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_lcd_ctrl_param;
  import lcd_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] IROM_Q;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [7:0] IRB_D;
  logic [5:0] IRB_A;
  logic       busy;
  logic       done;

  lcd_ctrl_param dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .IROM_Q    (IROM_Q),
    .IROM_EN   (IROM_EN),
    .IROM_A    (IROM_A),
    .IRB_RW    (IRB_RW),
    .IRB_D     (IRB_D),
    .IRB_A     (IRB_A),
    .busy      (busy),
    .done      (done)
  );

  int n_chk = 0;
  int n_err = 0;

  int rom    [64];
  int img    [64];
  int wb_mem [64];
  int mx, my;

  logic [15:0] sb [$];
  int done_cnt = 0;
  int overlap  = 0;
  bit prev63   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for an enabled address appears after the next edge.
  always @(posedge clk) begin
    if (!IROM_EN) IROM_Q <= 8'(rom[IROM_A]);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Write-back monitor: compares every IRB beat against the scoreboard.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset) begin
      if (!IROM_EN && !IRB_RW) overlap++;
      if (done) begin
        done_cnt++;
        check("done_after_a63", prev63, 1);
        check("done_rw_idle", IRB_RW, 1);
        check("done_not_busy", busy, 0);
      end
      if (!IRB_RW) begin
        e = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
        check("wb_addr", {26'd0, IRB_A}, {24'd0, e[15:8]});
        check("wb_data", {24'd0, IRB_D}, {24'd0, e[7:0]});
        wb_mem[IRB_A] = IRB_D;
      end
      prev63 = !IRB_RW && (IRB_A == 6'd63);
    end
  end

  function automatic void model_reload();
    for (int i = 0; i < 64; i++) img[i] = rom[i];
    mx = 4;
    my = 4;
  endfunction

  function automatic void model_cmd(input logic [3:0] c);
    int tl, tr, bl, br, a, b, d, e, m;
    tl = (my - 1) * 8 + (mx - 1);
    tr = tl + 1;
    bl = tl + 8;
    br = bl + 1;
    a = img[tl]; b = img[tr]; d = img[bl]; e = img[br];
    case (c)
      4'd1:  if (my > 1) my--;
      4'd2:  if (my < 7) my++;
      4'd3:  if (mx > 1) mx--;
      4'd4:  if (mx < 7) mx++;
      4'd5:  begin m = (a + b + d + e) / 4; img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m; end
      4'd6:  begin img[tl] = b; img[tr] = a; img[bl] = e; img[br] = d; end
      4'd7:  begin img[tl] = d; img[bl] = a; img[tr] = e; img[br] = b; end
      4'd8:  begin
        m = a; if (b > m) m = b; if (d > m) m = d; if (e > m) m = e;
        img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m;
      end
      4'd9:  begin
        m = a; if (b < m) m = b; if (d < m) m = d; if (e < m) m = e;
        img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m;
      end
      4'd10: begin img[tl] = d; img[tr] = a; img[br] = b; img[bl] = e; end
      4'd11: begin img[tl] = b; img[tr] = e; img[br] = d; img[bl] = a; end
      4'd12: begin mx = 4; my = 4; end
      4'd13: model_reload();
      default: ;
    endcase
  endfunction

  task automatic push_write();
    for (int i = 0; i < 64; i++) sb.push_back({8'(i), 8'(img[i])});
  endtask

  // Follows a ROM load until busy drops, checking the address sequence.
  task automatic load_check();
    int ea = 0;
    int k  = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
      if (!IROM_EN) begin
        check("rom_a", {26'd0, IROM_A}, ea);
        ea++;
      end
    end
    check("rom_cnt", ea, 64);
    check("load_done_busy", busy, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  // Issues one command from IDLE; poke drives a stray command while busy.
  task automatic do_cmd(input logic [3:0] c, input bit poke);
    int k;
    int dc;
    wait_idle();
    dc = done_cnt;
    if (c == 4'd0) push_write();
    model_cmd(c);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (c == 4'd0) begin
      check("wr_busy", busy, 1);
      k = 0;
      while (busy && k < 200) begin
        @(negedge clk);
        k++;
      end
      #1;
      check("wr_done_cnt", done_cnt, dc + 1);
      check("wr_sb_empty", sb.size(), 0);
    end else if (c == 4'd13) begin
      load_check();
    end else begin
      check("exec_busy", busy, 1);
      if (poke) begin
        cmd       = 4'd13;
        cmd_valid = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("exec_free", busy, 0);
      if (poke) begin
        @(negedge clk);
        check("poke_ignored", busy, 0);
      end
    end
  endtask

  initial begin
    int k;
    int dc;
    reset     = 1'b0;
    cmd       = 4'd0;
    cmd_valid = 1'b0;
    IROM_Q    = 8'd0;
    for (int i = 0; i < 64; i++) rom[i] = i;
    repeat (3) @(negedge clk);

    check("rst_irom_en", IROM_EN, 1);
    check("rst_irom_a", IROM_A, 0);
    check("rst_irb_rw", IRB_RW, 1);
    check("rst_irb_a", IRB_A, 0);
    check("rst_irb_d", IRB_D, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);

    reset = 1'b1;
    model_reload();
    load_check();
    do_cmd(CMD_WRITE, 0);
    check("load_px5", wb_mem[5], 5);

    do_cmd(CMD_AVG, 0);
    do_cmd(CMD_WRITE, 0);
    check("avg_a27", wb_mem[27], 31);
    check("avg_a28", wb_mem[28], 31);
    check("avg_a35", wb_mem[35], 31);
    check("avg_a36", wb_mem[36], 31);
    check("avg_a63", wb_mem[63], 63);

    do_cmd(CMD_RELOAD, 0);
    do_cmd(CMD_ROTCW, 0);
    do_cmd(CMD_WRITE, 0);
    check("rcw_a27", wb_mem[27], 35);
    check("rcw_a28", wb_mem[28], 27);
    check("rcw_a36", wb_mem[36], 28);
    check("rcw_a35", wb_mem[35], 36);
    do_cmd(CMD_ROTCCW, 0);
    do_cmd(CMD_WRITE, 0);
    check("rccw_a27", wb_mem[27], 27);
    check("rccw_a28", wb_mem[28], 28);
    check("rccw_a35", wb_mem[35], 35);
    check("rccw_a36", wb_mem[36], 36);

    for (int i = 0; i < 5; i++) do_cmd(CMD_LEFT, 0);
    for (int i = 0; i < 5; i++) do_cmd(CMD_UP, 0);
    do_cmd(CMD_MIRX, 0);
    do_cmd(CMD_WRITE, 0);
    check("corner_a0", wb_mem[0], 1);
    check("corner_a1", wb_mem[1], 0);
    check("corner_a8", wb_mem[8], 9);
    check("corner_a9", wb_mem[9], 8);
    check("corner_a10", wb_mem[10], 10);

    do_cmd(CMD_ORIGIN, 0);
    for (int i = 0; i < 5; i++) do_cmd(CMD_RIGHT, 0);
    for (int i = 0; i < 5; i++) do_cmd(CMD_DOWN, 0);
    do_cmd(CMD_MIRY, 0);
    do_cmd(4'd14, 0);
    do_cmd(CMD_WRITE, 0);
    check("far_a54", wb_mem[54], 62);
    check("far_a62", wb_mem[62], 54);
    check("far_a55", wb_mem[55], 63);
    check("far_a63", wb_mem[63], 55);

    for (int i = 0; i < 64; i++) rom[i] = 255 - i;
    do_cmd(CMD_RELOAD, 0);
    do_cmd(CMD_MAX, 1);
    do_cmd(CMD_MIN, 1);
    do_cmd(CMD_WRITE, 0);
    check("mm_a27", wb_mem[27], 228);
    check("mm_a28", wb_mem[28], 228);
    check("mm_a35", wb_mem[35], 228);
    check("mm_a36", wb_mem[36], 228);
    check("mm_a0", wb_mem[0], 255);

    // Reset in the middle of a write-back.
    wait_idle();
    push_write();
    cmd       = CMD_WRITE;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (IRB_A != 6'd20 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_hit_a20", IRB_A, 20);
    dc    = done_cnt;
    reset = 1'b0;
    #1;
    check("midrst_rw", IRB_RW, 1);
    check("midrst_busy", busy, 1);
    check("midrst_en", IROM_EN, 1);
    check("midrst_irb_a", IRB_A, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    model_reload();
    load_check();
    check("midrst_no_done", done_cnt, dc);
    do_cmd(CMD_WRITE, 0);
    check("post_a0", wb_mem[0], 255);
    check("post_a28", wb_mem[28], 227);

    check("done_total", done_cnt, 8);
    check("never_both_active", overlap, 0);
    check("sb_final", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
- Parametrised successor of the fixed 8x8 LCD image controller.
- Loads a W x H image of DW-bit pixels from the image ROM into an internal buffer, then executes host commands on a 2x2 operation window: move, average, mirror, max/min, rotate.
- Supports repeated write-back to the image RAM buffer (IRB) and ROM reload without reset.
- Sits between the host command interface and the IROM/IRB macros.

Parameters:
- IMG_W, 8, image width in pixels; power of 2, >=4.
- IMG_H, 8, image height in pixels; power of 2, >=4.
- DW, 8, pixel width in bits.
- AW, $clog2(IMG_W*IMG_H), derived address width; not overridden.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd  in  4  command code
- cmd_valid  in  1  command strobe; sampled only while busy=0
- IROM_Q  in  DW  ROM read data, valid one cycle after IROM_A with IROM_EN=0
- IROM_EN  out  1  ROM enable, active-low
- IROM_A  out  AW  ROM address
- IRB_RW  out  1  0=write, 1=idle
- IRB_D  out  DW  IRB write data
- IRB_A  out  AW  IRB address
- busy  out  1  controller cannot accept a command
- done  out  1  one-cycle pulse at end of a write-back

Behaviour:
- Reset values:
  - IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, busy=1, done=0.
  - Buffer cleared to 0; state=LOAD; x=IMG_W/2, y=IMG_H/2.
- Window: TL=(x-1,y-1), TR=(x,y-1), BL=(x-1,y), BR=(x,y). Address = row*IMG_W+col. x range 1..IMG_W-1; y range 1..IMG_H-1.
- LOAD:
  - IROM_EN=0; IROM_A steps 0..N-1, one per cycle (N=IMG_W*IMG_H).
  - IROM_Q captured into buffer[A-1] the following cycle.
  - Last capture one cycle after A=N-1; IROM_EN returns to 1 on that cycle. Then IDLE.
- IDLE:
  - busy=0.
  - cmd_valid=1 latches cmd; busy=1 from next cycle; state -> EXEC, WRITE or LOAD.
- EXEC: single cycle, buffer/coordinates updated at its end. Busy falls the following cycle. Command accepted at t: busy high t+1..t+1, low at t+2.
- Command codes:
  - 0 WRITE: write-back.
  - 1 UP: y-1 unless y=1.
  - 2 DOWN: y+1 unless y=IMG_H-1.
  - 3 LEFT: x-1 unless x=1.
  - 4 RIGHT: x+1 unless x=IMG_W-1.
  - 5 AVG: all four pixels = floor(sum/4); sum computed at DW+2 bits, no overflow.
  - 6 MIRX: TL<->TR, BL<->BR.
  - 7 MIRY: TL<->BL, TR<->BR.
  - 8 MAX: all four pixels = maximum of the window.
  - 9 MIN: all four pixels = minimum of the window.
  - 10 ROTCW: TL<-BL, TR<-TL, BR<-TR, BL<-BR.
  - 11 ROTCCW: inverse of ROTCW.
  - 12 ORIGIN: x=IMG_W/2, y=IMG_H/2.
  - 13 RELOAD: re-enter LOAD; buffer overwritten; coordinates reset to origin.
  - 14, 15: no-op, one EXEC cycle.
- Move at a boundary: coordinates unchanged, still one EXEC cycle.
- WRITE:
  - IRB_RW=0; IRB_A steps 0..N-1, one per cycle; IRB_D=buffer[IRB_A] in the same cycle.
  - Cycle after A=N-1: IRB_RW=1, done=1 for exactly one cycle, busy=0 that same cycle, state=IDLE.
  - Image and coordinates are retained; further commands and write-backs are allowed.
- cmd_valid while busy=1: ignored, no latch.
- reset asserted in any state: outputs and buffer go to reset values immediately. After release, LOAD restarts from address 0.
- IROM_EN and IRB_RW are never both active.

Decomposition:
- Package lcd_ctrl_pkg: cmd code localparams/enum (CMD_WRITE..CMD_RELOAD), state enum (LOAD, IDLE, EXEC, WRITE).
- Sub-module lcd_window_alu: purely combinational. Inputs: TL/TR/BL/BR and op. Outputs: four result pixels plus a write-enable. Holds AVG/MAX/MIN/MIRROR/ROTATE.
- Top holds the FSM, counters, coordinates and buffer.

Test Plan (defaults; ROM pixel[i]=i; window at origin is 27,28,35,36):
- Reset release -> IROM_A 0..63 with IROM_EN=0 for 64 cycles; busy falls; buffer[i]=i.
- AVG then WRITE -> IRB_D at A=27,28,35,36 = 31; all other addresses = i; done pulses once, one cycle after A=63.
- ROTCW then WRITE -> A27=35, A28=27, A36=28, A35=36. Then ROTCCW and WRITE again -> original values restored; two done pulses total.
- LEFT x5, then UP x5, then MIRX, then WRITE -> x=1,y=1; A0=1, A1=0, A8=9, A9=8.
- MAX then MIN on ROM pixel[i]=255-i -> window all 228 after MAX, still 228 after MIN; cmd_valid asserted while busy=1 is ignored.
- reset pulsed at IRB_A=20 during WRITE -> IRB_RW=1 and busy=1 immediately; full reload from A=0; no done pulse.
